// File: rtl/matmul_result_writeback.sv
// Captures a NUMLANES-row result matrix from the matmul array into per-lane RAMs,
// then drains it row by row to the VRF writeback port with a valid/ready handshake.
module matmul_result_writeback #(
    parameter int NUMLANES   = 8,
    parameter int DWIDTH     = 16,
    parameter int REGIDWIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [REGIDWIDTH-1:0]        in_dst,
    input  logic                         in_dst_we,
    input  logic [NUMLANES-1:0]          in_mask,
    input  logic [NUMLANES*DWIDTH-1:0]   c_data,
    input  logic                         c_data_available,
    output logic                         busy,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [REGIDWIDTH-1:0]        wb_dst,
    output logic [NUMLANES*DWIDTH-1:0]   wb_data,
    output logic [NUMLANES-1:0]          wb_mask,
    output logic                         done,
    output logic                         overflow
);
    localparam int CW = (NUMLANES > 1) ? $clog2(NUMLANES) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(NUMLANES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t                  state_reg;
    logic [CW-1:0]           row_cnt_reg;
    logic [REGIDWIDTH-1:0]   dst_reg;
    logic [REGIDWIDTH-1:0]   wb_dst_reg;
    logic                    we_reg;
    logic [NUMLANES-1:0]     mask_reg;
    logic                    wb_valid_reg;
    logic                    done_reg;
    logic                    overflow_reg;

    logic                    capture_row;
    logic                    last_capture;
    logic                    accept;
    logic                    load_first;
    logic                    advance;
    logic                    rd_en;
    logic [CW-1:0]           wr_addr;
    logic [CW-1:0]           rd_addr;

    always_comb begin
        capture_row  = c_data_available &&
                       ((state_reg == ARMED) || (state_reg == CAPTURE) ||
                        ((state_reg == IDLE) && start));
        wr_addr      = (state_reg == CAPTURE) ? row_cnt_reg : '0;
        last_capture = c_data_available && (state_reg == CAPTURE) && (row_cnt_reg == LAST_ROW);
        accept       = (state_reg == DRAIN) && wb_valid_reg && wb_ready;
        // Read data is registered, so the next row is fetched on the edge that
        // enters DRAIN or accepts the current row, keeping wb_data aligned with wb_dst.
        load_first   = last_capture && we_reg;
        advance      = accept && (row_cnt_reg != LAST_ROW);
        rd_en        = load_first || advance;
        rd_addr      = load_first ? '0 : row_cnt_reg + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUMLANES; gi++) begin : g_lane
            logic [DWIDTH-1:0] lane_mem [NUMLANES];
            logic [DWIDTH-1:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (capture_row) begin
                    lane_mem[wr_addr] <= c_data[gi*DWIDTH +: DWIDTH];
                end
                if (rd_en) begin
                    lane_q_reg <= lane_mem[rd_addr];
                end
            end

            assign wb_data[gi*DWIDTH +: DWIDTH] = lane_q_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            row_cnt_reg  <= '0;
            dst_reg      <= '0;
            wb_dst_reg   <= '0;
            we_reg       <= 1'b0;
            mask_reg     <= '0;
            wb_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dst_reg  <= in_dst;
                        we_reg   <= in_dst_we;
                        mask_reg <= in_mask;
                        if (c_data_available) begin
                            row_cnt_reg <= CW'(1);
                            state_reg   <= CAPTURE;
                        end else begin
                            state_reg <= ARMED;
                        end
                    end else if (c_data_available) begin
                        overflow_reg <= 1'b1;
                    end
                end
                ARMED: begin
                    if (c_data_available) begin
                        row_cnt_reg <= CW'(1);
                        state_reg   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (last_capture) begin
                        row_cnt_reg <= '0;
                        if (we_reg) begin
                            state_reg    <= DRAIN;
                            wb_valid_reg <= 1'b1;
                            wb_dst_reg   <= dst_reg;
                        end else begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end else if (c_data_available) begin
                        row_cnt_reg <= row_cnt_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (c_data_available) begin
                        overflow_reg <= 1'b1;
                    end
                    if (accept) begin
                        if (row_cnt_reg == LAST_ROW) begin
                            row_cnt_reg  <= '0;
                            wb_valid_reg <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= IDLE;
                        end else begin
                            row_cnt_reg <= row_cnt_reg + 1'b1;
                            wb_dst_reg  <= wb_dst_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign wb_valid = wb_valid_reg;
    assign wb_dst   = wb_dst_reg;
    assign wb_mask  = mask_reg;
    assign done     = done_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_matmul_result_writeback.sv
// Directed bench for matmul_result_writeback: a queue of expected writeback rows
// is built from each op's stimulus and checked against the DUT every cycle.
module tb_matmul_result_writeback;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int RW = N * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_dst;
    logic          in_dst_we;
    logic [N-1:0]  in_mask;
    logic [RW-1:0] c_data;
    logic          c_data_available;
    logic          busy;
    logic          wb_valid;
    logic          wb_ready;
    logic [7:0]    wb_dst;
    logic [RW-1:0] wb_data;
    logic [N-1:0]  wb_mask;
    logic          done;
    logic          overflow;

    matmul_result_writeback #(.NUMLANES(N), .DWIDTH(DW), .REGIDWIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_dst(in_dst), .in_dst_we(in_dst_we),
        .in_mask(in_mask), .c_data(c_data), .c_data_available(c_data_available),
        .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst),
        .wb_data(wb_data), .wb_mask(wb_mask), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    dst;
        logic [RW-1:0] data;
        logic [N-1:0]  mask;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    logic [7:0]    acc_dst[$];
    logic [RW-1:0] acc_data[$];

    int  checks = 0;
    int  errors = 0;
    bit  drop_flag = 0;
    bit  last_nowe = 0;
    bit  ready_mode = 0;
    bit  exp_ov = 0;
    bit  done_due = 0;
    bit  drain_active = 0;
    bit  prev_stall = 0;
    logic [7:0]    prev_dst;
    logic [RW-1:0] prev_data;

    task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [RW-1:0] row_word(input int base, input int r);
        logic [RW-1:0] w;
        for (int l = 0; l < N; l++) w[l*DW +: DW] = 16'(base + r * 16 + l);
        return w;
    endfunction

    // Per-cycle compare against the expected-row queue and flag model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                exp_ov = 0; done_due = 0; drain_active = 0; prev_stall = 0;
            end else begin
                check("done", RW'(done), RW'(done_due));
                done_due = 0;
                check("overflow", RW'(overflow), RW'(exp_ov));
                if (c_data_available && drop_flag) exp_ov = 1;
                if (c_data_available && last_nowe) done_due = 1;
                if (prev_stall) begin
                    check("stall_valid", RW'(wb_valid), RW'(1'b1));
                    check("stall_dst", RW'(wb_dst), RW'(prev_dst));
                    check("stall_data", wb_data, prev_data);
                end
                if (wb_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("spurious_wb_valid");
                    end else begin
                        check("wb_dst", RW'(wb_dst), RW'(exp_q[0].dst));
                        check("wb_data", wb_data, exp_q[0].data);
                        check("wb_mask", RW'(wb_mask), RW'(exp_q[0].mask));
                        drain_active = 1;
                        if (wb_ready) begin
                            acc_dst.push_back(wb_dst);
                            acc_data.push_back(wb_data);
                            if (exp_q[0].last) begin
                                done_due = 1;
                                drain_active = 0;
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end else if (drain_active && exp_q.size() > 0) begin
                    fail_now("wb_valid_gap");
                end
                prev_stall = wb_valid && !wb_ready;
                prev_dst   = wb_dst;
                prev_data  = wb_data;
            end
        end
    end

    // Ready generator: always 1, or the repeating 1,0,0 pattern.
    initial begin
        int rcnt = 0;
        wb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                wb_ready = (rcnt % 3 == 0);
                rcnt++;
            end else begin
                wb_ready = 1'b1;
            end
        end
    end

    task automatic run_op(input logic [7:0] dst, input bit we, input logic [N-1:0] mask,
                          input int base, input int gap_a, input int gap_b,
                          input bit same_cycle, input bit spam, input bit ovf_drain,
                          input bit abort);
        int   first;
        bit   got;
        logic [7:0] d;
        acc_dst.delete();
        acc_data.delete();
        @(posedge clk); #1;
        if (we) begin
            for (int r = 0; r < N; r++) begin
                d = dst + 8'(r);
                exp_q.push_back('{dst: d, data: row_word(base, r), mask: mask, last: (r == N - 1)});
            end
        end
        start = 1; in_dst = dst; in_dst_we = we; in_mask = mask;
        first = 0;
        if (same_cycle) begin
            c_data = row_word(base, 0);
            c_data_available = 1;
            first = 1;
        end
        @(posedge clk); #1;
        start = 0; in_dst = ~dst; in_dst_we = ~we; in_mask = ~mask;
        c_data_available = 0;
        for (int r = first; r < N; r++) begin
            c_data = row_word(base, r);
            c_data_available = 1;
            start = spam && (r == 3);
            last_nowe = (r == N - 1) && !we;
            @(posedge clk); #1;
            start = 0; c_data_available = 0; last_nowe = 0;
            if (r == gap_a || r == gap_b) begin
                repeat (2) begin @(posedge clk); #1; end
            end
        end
        @(negedge clk);
        if (!we) begin
            check("nowe_valid", RW'(wb_valid), RW'(1'b0));
            check("nowe_done", RW'(done), RW'(1'b1));
            return;
        end
        check("drain_start", RW'(wb_valid), RW'(1'b1));
        if (ovf_drain) begin
            @(posedge clk); #1;
            c_data = {RW{1'b1}}; c_data_available = 1; drop_flag = 1;
            @(posedge clk); #1;
            c_data_available = 0; drop_flag = 0;
        end
        if (abort) begin
            repeat (2) @(posedge clk);
            #1 reset = 1;
            @(posedge clk); #1 reset = 0;
            @(negedge clk);
            check("abort_valid", RW'(wb_valid), RW'(1'b0));
            check("abort_busy", RW'(busy), RW'(1'b0));
            check("abort_overflow", RW'(overflow), RW'(1'b0));
            return;
        end
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        if (!got) fail_now("done_timeout");
        check("idle_busy", RW'(busy), RW'(1'b0));
        check("rows_delivered", RW'(acc_dst.size()), RW'(N));
    endtask

    initial begin
        logic [RW-1:0] tmp;
        reset = 1; start = 0; in_dst = 0; in_dst_we = 0; in_mask = 0;
        c_data = '0; c_data_available = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_busy", RW'(busy), RW'(1'b0));
        check("rst_valid", RW'(wb_valid), RW'(1'b0));
        check("rst_done", RW'(done), RW'(1'b0));
        check("rst_overflow", RW'(overflow), RW'(1'b0));
        check("rst_wb_dst", RW'(wb_dst), RW'(8'h00));
        check("rst_wb_mask", RW'(wb_mask), RW'(8'h00));

        // Basic op, ready always high.
        run_op(8'h10, 1, 8'hFF, 0, -1, -1, 0, 0, 0, 0);
        check("pin_dst0", RW'(acc_dst[0]), RW'(8'h10));
        check("pin_dst7", RW'(acc_dst[7]), RW'(8'h17));
        tmp = acc_data[1];
        check("pin_row1_lane1", RW'(tmp[31:16]), RW'(16'h0011));

        // Stalling ready, with a start pulse mid-capture that must be ignored.
        ready_mode = 1;
        run_op(8'h10, 1, 8'hFF, 32'h100, -1, -1, 0, 1, 0, 0);
        ready_mode = 0;

        // Register-ID wrap, start coincident with row 0.
        run_op(8'hFE, 1, 8'hFF, 32'h200, -1, -1, 1, 0, 0, 0);
        check("pin_wrap2", RW'(acc_dst[2]), RW'(8'h00));
        check("pin_wrap7", RW'(acc_dst[7]), RW'(8'h05));

        // Two-cycle gaps after rows 2 and 5, partial mask.
        run_op(8'h30, 1, 8'h5A, 32'h300, 2, 5, 0, 0, 0, 0);

        // Dropped row in IDLE, then another drop during a stalled drain.
        @(posedge clk); #1;
        c_data = {RW{1'b1}}; c_data_available = 1; drop_flag = 1;
        @(posedge clk); #1;
        c_data_available = 0; drop_flag = 0;
        ready_mode = 1;
        run_op(8'h40, 1, 8'hC3, 32'h400, -1, -1, 0, 0, 1, 0);
        ready_mode = 0;
        check("overflow_sticky", RW'(overflow), RW'(1'b1));

        // Writeback disabled.
        run_op(8'h50, 0, 8'hFF, 32'h500, -1, -1, 0, 0, 0, 0);

        // Reset mid-drain, then a clean op afterwards.
        run_op(8'h60, 1, 8'hFF, 32'h600, -1, -1, 0, 0, 0, 1);
        run_op(8'h70, 1, 8'h0F, 32'h700, -1, -1, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matmul_result_writeback.md
Name: matmul_result_writeback

Overview:
- Result-side companion to the matmul unit.
- Captures the NUMLANES-row result matrix streamed out of the matmul array, one row per cycle, while c_data_available is high.
- Buffers the full matrix, then drains it row-by-row to the vector register file writeback port using a valid/ready handshake.
- Each row goes to consecutive destination registers, with the lane mask applied.
- Sits between the matmul unit outputs and the VRF write arbiter.

Parameters:
- NUMLANES, 8, matrix dimension = number of vector lanes = rows captured per operation.
- DWIDTH, 16, bits per result element.
- REGIDWIDTH, 8, destination register ID width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  arms block for one matmul op; latches in_dst/in_dst_we/in_mask.
- in_dst  input  REGIDWIDTH  base destination register for row 0.
- in_dst_we  input  1  writeback enable for this op.
- in_mask  input  NUMLANES  per-lane write mask applied to every row.
- c_data  input  NUMLANES*DWIDTH  one result row; lane i at bits [i*DWIDTH +: DWIDTH].
- c_data_available  input  1  c_data holds a valid row this cycle.
- busy  output  1  high whenever state != IDLE.
- wb_valid  output  1  writeback row valid.
- wb_ready  input  1  VRF accepts row this cycle.
- wb_dst  output  REGIDWIDTH  destination register of current row.
- wb_data  output  NUMLANES*DWIDTH  current row data.
- wb_mask  output  NUMLANES  latched in_mask.
- done  output  1  one-cycle pulse when the op completes.
- overflow  output  1  sticky: a row arrived when not accepting.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE; row_cnt = 0.
  - busy, wb_valid, done, overflow = 0.
  - wb_dst, wb_mask = 0.
  - Buffer contents are don't-care.
  - Reset mid-operation aborts the op immediately; no further wb_valid.
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE:
  - start=1 → latch dst/we/mask, go to ARMED.
  - If c_data_available=1 in the same cycle, row 0 is captured, row_cnt=1, go to CAPTURE.
  - c_data_available=1 without start → row dropped, overflow<=1.
- ARMED:
  - c_data_available=1 → write buffer[0], row_cnt=1, go to CAPTURE.
  - start is ignored.
- CAPTURE:
  - Each cycle with c_data_available=1 writes buffer[row_cnt] and increments row_cnt.
  - Gaps (available=0) hold row_cnt.
  - Capturing row NUMLANES-1 → row_cnt=0, go to DRAIN if latched we=1.
  - Otherwise (we=0) pulse done next cycle and go to IDLE.
- DRAIN:
  - wb_valid=1 starting the cycle after the last row is captured.
  - wb_data = buffer[row_cnt]; wb_dst = base_dst + row_cnt, modulo 2^REGIDWIDTH (wraps).
  - wb_valid && wb_ready → row_cnt++.
  - On acceptance of row NUMLANES-1: wb_valid drops next cycle, done=1 that cycle, state=IDLE.
  - While wb_valid && !wb_ready, wb_data/wb_dst/wb_mask hold stable.
  - c_data_available=1 in DRAIN → row dropped, overflow<=1.
  - start is ignored.
- overflow stays set until reset.
- Latency:
  - Row N captured at edge k → visible in buffer at k+1.
  - Minimum op = NUMLANES capture cycles + NUMLANES drain cycles, plus 1 cycle for done.
- start while busy (ARMED/CAPTURE/DRAIN) has no effect and must not corrupt the latched dst.
- A new op may start in the same cycle done is high (state is IDLE then).

Test Plan:
- start with in_dst=8'h10, we=1, mask=8'hFF; 8 back-to-back rows (row r lanes = r*16+lane); wb_ready=1 → wb_dst 0x10..0x17 on 8 consecutive cycles, data matches, done pulses once, overflow=0.
- Same op, wb_ready toggles 1,0,0,1… → every row delivered exactly once in order; wb_data/wb_dst stable during stalls.
- in_dst=8'hFE → wb_dst sequence FE,FF,00,01,…,05 (wrap).
- Rows arrive with 2-cycle gaps after rows 2 and 5 → all 8 rows captured correctly; drain begins one cycle after row 7.
- c_data_available pulsed in IDLE with no start, and again during DRAIN → overflow=1 and stays set; the in-flight drain is unaffected.
- in_dst_we=0 → no wb_valid, done pulses after row 7; separately, reset asserted mid-DRAIN → wb_valid=0, busy=0 next cycle.
